// File: rtl/except_ctrl_if.sv
// Pipeline <-> exception controller bundle: MEM-stage commit info, mtc0/mfc0 port,
// flush/redirect controls and CP0 state. int_i exists only when EXCEPT_INT_EN is defined.
interface except_ctrl_if;
  logic [31:0] excepttype_i;
  logic        inst_valid_i;
  logic        mem_stall_i;
  logic [31:0] pc_i;
  logic        in_delay_slot_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [31:0] cp0_wdata_i;
  logic [4:0]  cp0_raddr_i;
  logic [31:0] cp0_rdata_o;
`ifdef EXCEPT_INT_EN
  logic [5:0]  int_i;
`endif
  logic        flush_o;
  logic        redirect_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  modport master (
    output excepttype_i, inst_valid_i, mem_stall_i, pc_i, in_delay_slot_i,
           cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
`ifdef EXCEPT_INT_EN
           int_i,
`endif
    input  cp0_rdata_o, flush_o, redirect_o, new_pc_o, busy_o, status_o, cause_o, epc_o
  );

  modport slave (
    input  excepttype_i, inst_valid_i, mem_stall_i, pc_i, in_delay_slot_i,
           cp0_we_i, cp0_waddr_i, cp0_wdata_i, cp0_raddr_i,
`ifdef EXCEPT_INT_EN
           int_i,
`endif
    output cp0_rdata_o, flush_o, redirect_o, new_pc_o, busy_o, status_o, cause_o, epc_o
  );
endinterface

// File: rtl/except_ctrl.sv
// Exception/CP0 sequencer: resolves MEM-stage exception priority, owns Status/Cause/EPC
// and runs flush -> redirect. Hardware interrupts enabled by defining EXCEPT_INT_EN.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_n,
  except_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_flush, r_redirect, r_busy;
  logic [31:0] r_new_pc, r_target;

  logic [31:0] r_status;
  logic        r_bd;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic [5:0]  w_ip_hw;
  logic [31:0] w_cause;
  logic        w_int, w_inv, w_sys, w_eret, w_is_exc, w_commit, w_we;
  logic [4:0]  w_exccode;
  logic [31:0] w_epc_new;

`ifdef EXCEPT_INT_EN
  logic [5:0] r_ip_hw;
  assign w_ip_hw = r_ip_hw;
  assign w_int   = r_status[0] && !r_status[1] && |(w_cause[15:8] & r_status[15:8]);
`else
  assign w_ip_hw = 6'd0;
  assign w_int   = 1'b0;
`endif

  assign w_cause   = {r_bd, 15'd0, w_ip_hw, r_ip_sw, 1'b0, r_exccode, 2'b00};
  assign w_inv     = bus.excepttype_i[9];
  assign w_sys     = bus.excepttype_i[8];
  assign w_eret    = bus.excepttype_i[12];
  assign w_is_exc  = w_int | w_inv | w_sys;
  assign w_commit  = (r_state == S_IDLE) && bus.inst_valid_i && !bus.mem_stall_i &&
                     (w_is_exc | w_eret);
  assign w_exccode = w_int ? 5'd0 : (w_inv ? 5'd10 : 5'd8);
  assign w_epc_new = bus.in_delay_slot_i ? bus.pc_i - 32'd4 : bus.pc_i;
  assign w_we      = bus.cp0_we_i && !r_busy;

  // Only these excepttype bits carry meaning here.
  logic w_unused;
  assign w_unused = &{1'b0, bus.excepttype_i[31:13], bus.excepttype_i[11:10],
                      bus.excepttype_i[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_flush    <= 1'b0;
      r_redirect <= 1'b0;
      r_busy     <= 1'b0;
      r_new_pc   <= 32'd0;
      r_target   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (w_commit) begin
          r_state  <= S_FLUSH;
          r_cnt    <= CNT_LOAD;
          r_flush  <= 1'b1;
          r_busy   <= 1'b1;
          r_target <= w_is_exc ? EXC_VECTOR : r_epc;
        end
        S_FLUSH: if (r_cnt == 4'd0) begin
          r_state    <= S_REDIRECT;
          r_flush    <= 1'b0;
          r_redirect <= 1'b1;
          r_new_pc   <= r_target;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        default: begin
          r_state    <= S_IDLE;
          r_redirect <= 1'b0;
          r_busy     <= 1'b0;
          r_new_pc   <= 32'd0;
        end
      endcase
    end
  end

  // mtc0 is applied first so a same-cycle commit overrides the fields it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status  <= 32'd0;
      r_bd      <= 1'b0;
      r_ip_sw   <= 2'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
`ifdef EXCEPT_INT_EN
      r_ip_hw   <= 6'd0;
`endif
    end else begin
`ifdef EXCEPT_INT_EN
      r_ip_hw <= bus.int_i;
`endif
      if (w_we) begin
        case (bus.cp0_waddr_i)
          5'd12:   r_status <= bus.cp0_wdata_i & 32'h0000_FF03;
          5'd13:   r_ip_sw  <= bus.cp0_wdata_i[9:8];
          5'd14:   r_epc    <= bus.cp0_wdata_i;
          default: ;
        endcase
      end
      if (w_commit) begin
        if (w_is_exc) begin
          r_exccode <= w_exccode;
          if (!r_status[1]) begin
            r_bd  <= bus.in_delay_slot_i;
            r_epc <= w_epc_new;
          end
          r_status[1] <= 1'b1;
        end else begin
          r_status[1] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    bus.cp0_rdata_o = 32'd0;
    case (bus.cp0_raddr_i)
      5'd12:   bus.cp0_rdata_o = r_status;
      5'd13:   bus.cp0_rdata_o = w_cause;
      5'd14:   bus.cp0_rdata_o = r_epc;
      default: ;
    endcase
  end

  assign bus.flush_o    = r_flush;
  assign bus.redirect_o = r_redirect;
  assign bus.new_pc_o   = r_new_pc;
  assign bus.busy_o     = r_busy;
  assign bus.status_o   = r_status;
  assign bus.cause_o    = w_cause;
  assign bus.epc_o      = r_epc;
endmodule

// File: tb/tb_except_ctrl.sv
// Directed bench for except_ctrl: CP0 access, priority, flush/redirect timing, stall, reset abort.
module tb_except_ctrl;
  localparam int          FC  = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  except_ctrl_if bus();
  except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we_i = 1'b1; bus.cp0_waddr_i = a; bus.cp0_wdata_i = d;
    tick;
    bus.cp0_we_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    bus.cp0_raddr_i = a;
    #1;
    chk(tag, bus.cp0_rdata_o, exp);
  endtask

  // hold: keep the exception asserted and attempt an EPC write while busy.
  task automatic do_seq(input string tag, input logic [31:0] exc, input logic [31:0] pc,
                        input logic ds, input logic [31:0] tgt, input logic hold);
    bus.excepttype_i = exc; bus.pc_i = pc; bus.in_delay_slot_i = ds; bus.inst_valid_i = 1'b1;
    tick;
    if (hold) begin
      bus.cp0_we_i = 1'b1; bus.cp0_waddr_i = 5'd14; bus.cp0_wdata_i = 32'h40;
    end else begin
      bus.excepttype_i = 32'd0;
    end
    for (int i = 0; i < FC; i++) begin
      chk({tag, "_flush"}, bus.flush_o, 1);
      chk({tag, "_busy"}, bus.busy_o, 1);
      chk({tag, "_noredir"}, bus.redirect_o, 0);
      tick;
    end
    bus.excepttype_i = 32'd0; bus.cp0_we_i = 1'b0;
    chk({tag, "_redir"}, bus.redirect_o, 1);
    chk({tag, "_newpc"}, bus.new_pc_o, tgt);
    chk({tag, "_flushoff"}, bus.flush_o, 0);
    tick;
    bus.inst_valid_i = 1'b0;
    chk({tag, "_redir_end"}, bus.redirect_o, 0);
    chk({tag, "_idle"}, bus.busy_o, 0);
    chk({tag, "_newpc0"}, bus.new_pc_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.excepttype_i = 32'd0; bus.inst_valid_i = 1'b0; bus.mem_stall_i = 1'b0;
    bus.pc_i = 32'd0; bus.in_delay_slot_i = 1'b0; bus.cp0_we_i = 1'b0;
    bus.cp0_waddr_i = 5'd0; bus.cp0_wdata_i = 32'd0; bus.cp0_raddr_i = 5'd0;
`ifdef EXCEPT_INT_EN
    bus.int_i = 6'd0;
`endif
    repeat (2) tick;
    rst_n = 1'b1;
    chk("rst_status", bus.status_o, 0);
    chk("rst_cause", bus.cause_o, 0);
    chk("rst_epc", bus.epc_o, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_redir", bus.redirect_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_newpc", bus.new_pc_o, 0);

    // CP0 write masks and reads
    mtc0(5'd12, 32'hFFFF_FFFF);
    rd("status_mask", 5'd12, 32'h0000_FF03);
    mtc0(5'd12, 32'd0);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_mask", 5'd13, 32'h0000_0300);
    mtc0(5'd13, 32'd0);
    mtc0(5'd14, 32'h1234_5678);
    rd("epc_rw", 5'd14, 32'h1234_5678);
    mtc0(5'd5, 32'hDEAD_BEEF);
    rd("other_reg", 5'd5, 32'd0);

    // syscall
    do_seq("sys", 32'h100, 32'h8000_0010, 1'b0, VEC, 1'b0);
    chk("sys_code", bus.cause_o & 32'h7C, 32'h20);
    chk("sys_epc", bus.epc_o, 32'h8000_0010);
    chk("sys_exl", bus.status_o[1], 1);

    // eret, EPC write during busy ignored
    do_seq("eret", 32'h1000, 32'h8000_0020, 1'b0, 32'h8000_0010, 1'b1);
    chk("eret_exl", bus.status_o[1], 0);
    chk("eret_epc", bus.epc_o, 32'h8000_0010);

    // invalid beats syscall, delay slot
    do_seq("inv", 32'h300, 32'h100, 1'b1, VEC, 1'b0);
    chk("inv_code", bus.cause_o & 32'h7C, 32'h28);
    chk("inv_epc", bus.epc_o, 32'hFC);
    chk("inv_bd", bus.cause_o[31], 1);

    // nested with EXL=1
    do_seq("nest", 32'h100, 32'h200, 1'b0, VEC, 1'b0);
    chk("nest_code", bus.cause_o & 32'h7C, 32'h20);
    chk("nest_epc", bus.epc_o, 32'hFC);
    chk("nest_bd", bus.cause_o[31], 1);

    // eret with irrelevant bits set
    do_seq("eret2", 32'h10FF, 32'h300, 1'b0, 32'hFC, 1'b0);
    chk("eret2_exl", bus.status_o[1], 0);

    // stall blocks commit
    bus.excepttype_i = 32'h100; bus.pc_i = 32'h300; bus.in_delay_slot_i = 1'b0;
    bus.inst_valid_i = 1'b1; bus.mem_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_noflush", bus.flush_o, 0);
      chk("stall_nobusy", bus.busy_o, 0);
    end
    bus.mem_stall_i = 1'b0;
    do_seq("stall", 32'h100, 32'h300, 1'b0, VEC, 1'b1);
    chk("stall_epc", bus.epc_o, 32'h300);
    tick;
    chk("stall_once", bus.busy_o, 0);

    // reset mid-sequence
    mtc0(5'd12, 32'd0);
    bus.excepttype_i = 32'h100; bus.pc_i = 32'h500; bus.inst_valid_i = 1'b1;
    tick;
    bus.excepttype_i = 32'd0; bus.inst_valid_i = 1'b0;
    tick;
    rst_n = 1'b0;
    #1;
    chk("abort_flush", bus.flush_o, 0);
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_epc", bus.epc_o, 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("abort_noredir", bus.redirect_o, 0);
      chk("abort_idle", bus.busy_o, 0);
    end

`ifdef EXCEPT_INT_EN
    mtc0(5'd12, 32'h0000_0400);
    bus.int_i = 6'd1;
    tick;
    do_seq("int_off", 32'h100, 32'h400, 1'b0, VEC, 1'b0);
    chk("int_off_code", bus.cause_o & 32'h7C, 32'h20);
    do_seq("int_eret", 32'h1000, 32'h404, 1'b0, 32'h400, 1'b0);
    mtc0(5'd12, 32'h0000_0401);
    do_seq("int_on", 32'h100, 32'h600, 1'b0, VEC, 1'b0);
    chk("int_on_code", bus.cause_o & 32'h7C, 32'h0);
    chk("int_on_epc", bus.epc_o, 32'h600);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception/CP0 sequencer for the pipelined CPU. Takes the 32-bit exception-type word carried down the pipeline (bit 8 syscall, bit 9 invalid instruction, bit 12 eret) at the MEM commit point and resolves priority. It also owns the Status/Cause/EPC registers and drives a multi-cycle flush-then-redirect sequence into the pipeline registers and the PC unit.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, handler entry address driven on redirect for all non-eret exceptions
- FLUSH_CYCLES, 2, cycles flush_o is held high (legal 1..15)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- excepttype_i  in  32  exception word from EX/MEM register
- inst_valid_i  in  1  MEM stage holds a real instruction (not a bubble)
- mem_stall_i  in  1  MEM stage stalled; no commit this cycle
- pc_i  in  32  PC of MEM-stage instruction
- in_delay_slot_i  in  1  MEM instruction is in a branch delay slot
- cp0_we_i  in  1  mtc0 write strobe
- cp0_waddr_i  in  5  mtc0 register number
- cp0_wdata_i  in  32  mtc0 data
- cp0_raddr_i  in  5  mfc0 register number
- cp0_rdata_o  out  32  mfc0 data (combinational)
- int_i  in  6  hardware interrupt lines (only with EXCEPT_INT_EN)
- flush_o  out  1  clear IF/ID, ID/EX, EX/MEM registers
- redirect_o  out  1  one-cycle PC load strobe
- new_pc_o  out  32  PC load value, valid while redirect_o
- busy_o  out  1  sequence in progress; pipeline must freeze fetch
- status_o, cause_o, epc_o  out  32 each  current CP0 values

## Operation
- Registers: Status (12), Cause (13), EPC (14); other addresses read 0. Writable: Status[15:8] IM, [1] EXL, [0] IE; Cause[9:8]; EPC all bits. Others read 0.
- Commit condition: state IDLE && inst_valid_i && !mem_stall_i && event pending.
- Priority: interrupt (ExcCode 0) > invalid (bit 9, ExcCode 10) > syscall (bit 8, ExcCode 8) > eret (bit 12). Only the highest is taken; others dropped.
- Exception commit: Cause[6:2] <= ExcCode; Cause[31] <= in_delay_slot_i; if Status.EXL==0, EPC <= in_delay_slot_i ? pc_i-4 : pc_i (modulo 2^32); if EXL already 1, EPC and BD unchanged. Status.EXL <= 1. Target = EXC_VECTOR.
- eret commit: Status.EXL <= 0; target = EPC (value before any same-cycle write).
- States: IDLE -> FLUSH on commit; FLUSH holds FLUSH_CYCLES cycles (down-counter) -> REDIRECT; REDIRECT one cycle -> IDLE.
- flush_o=1 in FLUSH; redirect_o=1 and new_pc_o=target in REDIRECT; busy_o=1 in FLUSH and REDIRECT. new_pc_o=0 otherwise.
- While busy_o, excepttype_i, int_i sampling for commit and cp0_we_i are ignored.
- Same cycle cp0 write and commit: commit wins on every field it updates; write applies to remaining fields.
- excepttype_i bits other than 8/9/12 ignored.

## Timing
- Reset (async, rst_n=0): state IDLE, counter 0, Status=Cause=EPC=0, flush_o=redirect_o=busy_o=0, new_pc_o=0.
- Commit in cycle T: CP0 updated at edge ending T; flush_o high T+1..T+FLUSH_CYCLES; redirect_o high T+FLUSH_CYCLES+1; IDLE at T+FLUSH_CYCLES+2.
- mtc0 visible on cp0_rdata_o the cycle after write; reads combinational.
- mem_stall_i high blocks commit indefinitely; event commits on first unstalled cycle.
- Reset mid-sequence aborts immediately; no redirect issued.

## Configuration
- EXCEPT_INT_EN defined: int_i sampled into Cause[15:10] every cycle (registered); interrupt pending = Status.IE && !Status.EXL && |(Cause[15:8] & Status[15:8]); EPC = pc_i (instruction not executed, BD rule still applies).
- Undefined: int_i port absent, Cause[15:10] read 0, only software Cause[9:8] can set IP bits but never raise an interrupt.

## Test plan
- Syscall at pc_i=0x8000_0010, no delay slot, FLUSH_CYCLES=2 -> Cause[6:2]=8, EPC=0x8000_0010, EXL=1; flush_o 2 cycles; redirect_o with new_pc_o=0xBFC0_0380.
- Invalid+syscall together (excepttype 0x300), in_delay_slot_i=1, pc_i=0x100 -> ExcCode 10, EPC=0xFC, Cause[31]=1.
- eret after above with EPC=0x8000_0010 -> EXL=0, redirect to 0x8000_0010; mtc0 EPC=0x40 same cycle ignored (busy starts next) and EPC target unchanged.
- Syscall with mem_stall_i high 3 cycles -> no flush until stall drops, then normal sequence; second syscall during busy ignored.
- EXL=1 nested syscall at pc 0x200 -> EPC unchanged, ExcCode 8, redirect to vector.
- EXCEPT_INT_EN: IE=1, IM[10]=1, int_i[0]=1, syscall present -> ExcCode 0 taken, EPC=pc_i; with IE=0 syscall taken instead.
